// File: rtl/bp_nonsynth_if_monitor_if.sv
// Ready/valid bundle for num_chan_p channels observed by bp_nonsynth_if_monitor.
// Channel c payload lives at data[c*width_p +: width_p].
interface bp_nonsynth_if_monitor_if #(
    parameter int unsigned num_chan_p = 4,
    parameter int unsigned width_p    = 64
);
    logic [num_chan_p-1:0]         v;
    logic [num_chan_p-1:0]         ready;
    logic [num_chan_p*width_p-1:0] data;

    modport master (output v, data, input ready);
    modport slave  (input v, data, output ready);
    modport mon    (input v, ready, data);
endinterface

// File: rtl/bp_nonsynth_if_monitor.sv
// Cycle-level ready/valid protocol checker: drop, instability, stall timeout and req/resp credit.
// Optional macro BP_NONSYNTH_IF_MONITOR_FATAL_EN: first error raises $error, then $finish a cycle later.
module bp_nonsynth_if_monitor #(
    parameter int unsigned num_chan_p        = 4,
    parameter int unsigned width_p           = 64,
    parameter int unsigned timeout_cycles_p  = 1024,
    parameter int unsigned req_chan_p        = 0,
    parameter int unsigned resp_chan_p       = 1,
    parameter int unsigned max_outstanding_p = 8,
    parameter int unsigned cnt_width_p       = 32
) (
    input  logic                                          clk_i,
    input  logic                                          reset_i,
    input  logic                                          freeze_i,
    bp_nonsynth_if_monitor_if.mon                         bus,
    output logic [num_chan_p*cnt_width_p-1:0]             fire_cnt_o,
    output logic [$clog2(max_outstanding_p+1)-1:0]        outstanding_o,
    output logic                                          err_v_o,
    output logic [2:0]                                    err_code_o,
    output logic [((num_chan_p > 1) ? $clog2(num_chan_p) : 1)-1:0] err_chan_o
);
    localparam int unsigned out_w_lp   = $clog2(max_outstanding_p + 1);
    localparam int unsigned chan_w_lp  = (num_chan_p > 1) ? $clog2(num_chan_p) : 1;
    localparam int unsigned stall_w_lp = $clog2(timeout_cycles_p + 1);

    if (req_chan_p >= num_chan_p || resp_chan_p >= num_chan_p) begin : g_bad_chan
        $fatal(1, "bp_nonsynth_if_monitor: req/resp channel out of range");
    end
    if (timeout_cycles_p == 0) begin : g_bad_timeout
        $fatal(1, "bp_nonsynth_if_monitor: timeout_cycles_p must be nonzero");
    end

    typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_e;

    localparam logic [stall_w_lp-1:0] stall_max_lp = stall_w_lp'(timeout_cycles_p);
    localparam logic [out_w_lp-1:0]   out_max_lp   = out_w_lp'(max_outstanding_p);

    state_e                state_q [num_chan_p];
    state_e                state_n [num_chan_p];
    logic [width_p-1:0]    cap_q   [num_chan_p];
    logic [width_p-1:0]    cap_n   [num_chan_p];
    logic [stall_w_lp-1:0] stall_q [num_chan_p];
    logic [stall_w_lp-1:0] stall_n [num_chan_p];
    logic [width_p-1:0]    data_ch [num_chan_p];

    logic [num_chan_p-1:0]      fire;
    // Bit k of ch_err[c] set means error code k+1 raised on channel c this cycle.
    logic [num_chan_p-1:0][4:0] ch_err;
    logic [out_w_lp-1:0]        out_n;
    logic                       ovf, unf;
    logic                       sel_v;
    logic [2:0]                 sel_code;
    logic [chan_w_lp-1:0]       sel_chan;

    assign fire = bus.v & bus.ready;

    for (genvar g = 0; g < int'(num_chan_p); g++) begin : g_slice
        assign data_ch[g] = bus.data[g*width_p +: width_p];
    end

    // Credit tracking between the request and response channels.
    always_comb begin : credit_next
        out_n = outstanding_o;
        ovf   = 1'b0;
        unf   = 1'b0;
        if (fire[req_chan_p] && !fire[resp_chan_p]) begin
            if (outstanding_o == out_max_lp) ovf = 1'b1;
            else                             out_n = outstanding_o + out_w_lp'(1);
        end else if (fire[resp_chan_p] && !fire[req_chan_p]) begin
            if (outstanding_o == '0) unf = 1'b1;
            else                     out_n = outstanding_o - out_w_lp'(1);
        end
    end

    // Per-channel handshake FSM next state and error detection.
    always_comb begin : chan_next
        for (int c = 0; c < int'(num_chan_p); c++) begin
            state_n[c] = state_q[c];
            cap_n[c]   = cap_q[c];
            stall_n[c] = stall_q[c];
            ch_err[c]  = '0;
            case (state_q[c])
                IDLE: begin
                    if (bus.v[c] && !bus.ready[c]) begin
                        state_n[c] = PEND;
                        cap_n[c]   = data_ch[c];
                        stall_n[c] = stall_w_lp'(1);
                        if (stall_max_lp == stall_w_lp'(1)) ch_err[c][2] = 1'b1;
                    end
                end
                PEND: begin
                    if (!bus.v[c]) begin
                        ch_err[c][0] = 1'b1;
                        state_n[c]   = IDLE;
                        stall_n[c]   = '0;
                    end else begin
                        if (data_ch[c] != cap_q[c]) begin
                            ch_err[c][1] = 1'b1;
                            cap_n[c]     = data_ch[c];
                        end
                        if (bus.ready[c]) begin
                            state_n[c] = IDLE;
                            stall_n[c] = '0;
                        end else if (stall_q[c] != stall_max_lp) begin
                            // Saturating count: the timeout fires only on the crossing.
                            stall_n[c] = stall_q[c] + stall_w_lp'(1);
                            if (stall_n[c] == stall_max_lp) ch_err[c][2] = 1'b1;
                        end
                    end
                end
                default: state_n[c] = IDLE;
            endcase
        end
        if (ovf) ch_err[req_chan_p][3]  = 1'b1;
        if (unf) ch_err[resp_chan_p][4] = 1'b1;
    end

    // Lowest channel wins, then the lowest code within that channel.
    always_comb begin : err_select
        sel_v    = 1'b0;
        sel_code = '0;
        sel_chan = '0;
        for (int c = int'(num_chan_p) - 1; c >= 0; c--) begin
            if (|ch_err[c]) begin
                sel_v    = 1'b1;
                sel_chan = chan_w_lp'(c);
                for (int k = 4; k >= 0; k--) begin
                    if (ch_err[c][k]) sel_code = 3'(k + 1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin : state_reg
        if (reset_i) begin
            for (int c = 0; c < int'(num_chan_p); c++) begin
                state_q[c] <= IDLE;
                cap_q[c]   <= '0;
                stall_q[c] <= '0;
            end
            fire_cnt_o    <= '0;
            outstanding_o <= '0;
            err_v_o       <= 1'b0;
            err_code_o    <= '0;
            err_chan_o    <= '0;
        end else if (!freeze_i) begin
            for (int c = 0; c < int'(num_chan_p); c++) begin
                state_q[c] <= state_n[c];
                cap_q[c]   <= cap_n[c];
                stall_q[c] <= stall_n[c];
                fire_cnt_o[c*cnt_width_p +: cnt_width_p] <=
                    fire_cnt_o[c*cnt_width_p +: cnt_width_p] + cnt_width_p'(fire[c]);
            end
            outstanding_o <= out_n;
            if (!err_v_o && sel_v) begin
                err_v_o    <= 1'b1;
                err_code_o <= sel_code;
                err_chan_o <= sel_chan;
            end
        end
    end

`ifndef SYNTHESIS
    // Report every error, not just the first one latched into err_*.
    always @(posedge clk_i) begin : err_report
        if (!reset_i && !freeze_i) begin
            for (int c = 0; c < int'(num_chan_p); c++) begin
                for (int k = 0; k < 5; k++) begin
                    if (ch_err[c][k])
                        $display("%0t bp_nonsynth_if_monitor: protocol error chan=%0d code=%0d",
                                 $time, c, k + 1);
                end
            end
        end
    end
`endif

`ifdef BP_NONSYNTH_IF_MONITOR_FATAL_EN
    logic fatal_q;

    always @(posedge clk_i or posedge reset_i) begin : fatal_stop
        if (reset_i) begin
            fatal_q <= 1'b0;
        end else begin
            if (fatal_q) $finish;
            if (!freeze_i && !err_v_o && sel_v) begin
                $error("bp_nonsynth_if_monitor: first error chan=%0d code=%0d", sel_chan, sel_code);
                fatal_q <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bp_nonsynth_if_monitor.sv
// Bench for bp_nonsynth_if_monitor: directed vector table, hand sequences, random vs reference model.
module tb_bp_nonsynth_if_monitor;
    localparam int unsigned NC   = 4;
    localparam int unsigned W    = 8;
    localparam int unsigned T    = 16;
    localparam int unsigned MAXO = 2;
    localparam int unsigned CW   = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic freeze = 1'b0;
    logic [NC*CW-1:0] fire_cnt;
    logic [1:0]       outstanding;
    logic             err_v;
    logic [2:0]       err_code;
    logic [1:0]       err_chan;

    int total = 0;
    int bad   = 0;

    bp_nonsynth_if_monitor_if #(.num_chan_p(NC), .width_p(W)) bus ();

    bp_nonsynth_if_monitor #(
        .num_chan_p(NC), .width_p(W), .timeout_cycles_p(T), .req_chan_p(0),
        .resp_chan_p(1), .max_outstanding_p(MAXO), .cnt_width_p(CW)
    ) dut (
        .clk_i(clk), .reset_i(rst), .freeze_i(freeze), .bus(bus),
        .fire_cnt_o(fire_cnt), .outstanding_o(outstanding), .err_v_o(err_v),
        .err_code_o(err_code), .err_chan_o(err_chan)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        frz;
        logic [3:0]  v;
        logic [3:0]  r;
        logic [31:0] d;
        logic [31:0] cnt;
        logic [1:0]  out;
        logic        ev;
        logic [2:0]  code;
        logic [1:0]  chan;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rs, logic fz, logic [3:0] v, logic [3:0] r, logic [31:0] d,
                                logic [31:0] cnt, logic [1:0] out, logic ev, logic [2:0] code,
                                logic [1:0] chan);
        vec_t t;
        t.rst = rs; t.frz = fz; t.v = v; t.r = r; t.d = d;
        t.cnt = cnt; t.out = out; t.ev = ev; t.code = code; t.chan = chan;
        return t;
    endfunction

    task automatic cmp(input string nm, input string fld, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s.%s got=%0h want=%0h", nm, fld, got, want);
        end
    endtask

    task automatic check(input string nm, input logic [31:0] ec, input logic [1:0] eo, input logic ev,
                         input logic [2:0] ecode, input logic [1:0] ech);
        cmp(nm, "fire_cnt", fire_cnt, ec);
        cmp(nm, "outstanding", 32'(outstanding), 32'(eo));
        cmp(nm, "err_v", 32'(err_v), 32'(ev));
        cmp(nm, "err_code", 32'(err_code), 32'(ecode));
        cmp(nm, "err_chan", 32'(err_chan), 32'(ech));
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] r, input logic [31:0] d);
        bus.v = v; bus.ready = r; bus.data = d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; freeze = 1'b0; drive(4'h0, 4'h0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Reference model: transaction-level view of each channel plus a credit count.
    int  m_pend[NC], m_held[NC], m_wait[NC], m_cnt[NC];
    int  m_out, m_code, m_chan, best_c, best_k;
    bit  m_ev;

    task automatic m_reset();
        for (int c = 0; c < int'(NC); c++) begin
            m_pend[c] = 0; m_held[c] = 0; m_wait[c] = 0; m_cnt[c] = 0;
        end
        m_out = 0; m_ev = 0; m_code = 0; m_chan = 0;
    endtask

    task automatic raise(input int c, input int k);
        if (c < best_c || (c == best_c && k < best_k)) begin
            best_c = c; best_k = k;
        end
    endtask

    task automatic m_step(input logic [3:0] v, input logic [3:0] r, input logic [31:0] d);
        int dc, delta;
        best_c = 99; best_k = 99;
        for (int c = 0; c < int'(NC); c++) begin
            dc = int'(d[c*W +: W]);
            if (m_pend[c] == 0) begin
                if (v[c] && !r[c]) begin
                    m_pend[c] = 1; m_held[c] = dc; m_wait[c] = 1;
                    if (m_wait[c] == int'(T)) raise(c, 3);
                end
            end else if (!v[c]) begin
                raise(c, 1); m_pend[c] = 0;
            end else begin
                if (dc != m_held[c]) begin raise(c, 2); m_held[c] = dc; end
                if (r[c]) m_pend[c] = 0;
                else if (m_wait[c] < int'(T)) begin
                    m_wait[c]++;
                    if (m_wait[c] == int'(T)) raise(c, 3);
                end
            end
            if (v[c] && r[c]) m_cnt[c] = (m_cnt[c] + 1) % (1 << CW);
        end
        delta = int'(v[0] && r[0]) - int'(v[1] && r[1]);
        if (delta == 1) begin
            if (m_out == int'(MAXO)) raise(0, 4); else m_out++;
        end else if (delta == -1) begin
            if (m_out == 0) raise(1, 5); else m_out--;
        end
        if (!m_ev && best_c != 99) begin
            m_ev = 1; m_code = best_k; m_chan = best_c;
        end
    endtask

    function automatic logic [31:0] m_cnt_packed();
        logic [31:0] p;
        for (int c = 0; c < int'(NC); c++) p[c*CW +: CW] = CW'(m_cnt[c]);
        return p;
    endfunction

    logic [3:0] cv, cr, fired;
    logic [7:0] cd[NC];
    int         bias[NC];

    initial begin
        drive(4'h0, 4'h0, 32'h0);
        // rst frz v r data | cnt out ev code chan
        tbl.push_back(mk(1,0,4'b0000,4'b0000,32'h0,        32'h0,      0,0,0,0));
        tbl.push_back(mk(0,0,4'b0001,4'b0000,32'hA5,       32'h0,      0,0,0,0));
        tbl.push_back(mk(0,0,4'b0001,4'b0000,32'hA5,       32'h0,      0,0,0,0));
        tbl.push_back(mk(0,0,4'b0001,4'b0000,32'hA5,       32'h0,      0,0,0,0));
        tbl.push_back(mk(0,0,4'b0001,4'b0001,32'hA5,       32'h1,      1,0,0,0));
        tbl.push_back(mk(0,0,4'b0000,4'b0000,32'h0,        32'h1,      1,0,0,0));
        tbl.push_back(mk(0,0,4'b0100,4'b0000,32'h0,        32'h1,      1,0,0,0));
        tbl.push_back(mk(0,0,4'b0000,4'b0000,32'h0,        32'h1,      1,1,1,2));
        tbl.push_back(mk(1,0,4'b0000,4'b0000,32'h0,        32'h0,      0,0,0,0));
        tbl.push_back(mk(0,0,4'b0010,4'b0000,32'h1000,     32'h0,      0,0,0,0));
        tbl.push_back(mk(0,0,4'b0010,4'b0000,32'h1100,     32'h0,      0,1,2,1));
        tbl.push_back(mk(0,0,4'b0010,4'b0010,32'h1100,     32'h100,    0,1,2,1));
        tbl.push_back(mk(1,0,4'b0000,4'b0000,32'h0,        32'h0,      0,0,0,0));
        tbl.push_back(mk(0,0,4'b0001,4'b0001,32'h0,        32'h1,      1,0,0,0));
        tbl.push_back(mk(0,0,4'b0001,4'b0001,32'h0,        32'h2,      2,0,0,0));
        tbl.push_back(mk(0,0,4'b0001,4'b0001,32'h0,        32'h3,      2,1,4,0));
        tbl.push_back(mk(0,0,4'b0011,4'b0011,32'h0,        32'h104,    2,1,4,0));
        tbl.push_back(mk(1,0,4'b0000,4'b0000,32'h0,        32'h0,      0,0,0,0));
        tbl.push_back(mk(0,0,4'b0010,4'b0010,32'h0,        32'h100,    0,1,5,1));
        tbl.push_back(mk(1,0,4'b0000,4'b0000,32'h0,        32'h0,      0,0,0,0));
        tbl.push_back(mk(0,0,4'b1010,4'b0000,32'h20001000, 32'h0,      0,0,0,0));
        tbl.push_back(mk(0,0,4'b0010,4'b0000,32'h1100,     32'h0,      0,1,2,1));
        tbl.push_back(mk(1,0,4'b0000,4'b0000,32'h0,        32'h0,      0,0,0,0));
        tbl.push_back(mk(0,0,4'b0100,4'b0000,32'h330000,   32'h0,      0,0,0,0));
        tbl.push_back(mk(0,1,4'b0000,4'b0000,32'h0,        32'h0,      0,0,0,0));
        tbl.push_back(mk(0,1,4'b0100,4'b0100,32'h330000,   32'h0,      0,0,0,0));
        tbl.push_back(mk(0,0,4'b0100,4'b0000,32'h440000,   32'h0,      0,1,2,2));
        tbl.push_back(mk(1,0,4'b0000,4'b0000,32'h0,        32'h0,      0,0,0,0));
        tbl.push_back(mk(0,0,4'b0010,4'b0000,32'h1000,     32'h0,      0,0,0,0));
        tbl.push_back(mk(0,0,4'b0010,4'b0010,32'h1100,     32'h100,    0,1,2,1));
        tbl.push_back(mk(1,0,4'b0000,4'b0000,32'h0,        32'h0,      0,0,0,0));
        tbl.push_back(mk(0,0,4'b0001,4'b0001,32'h0,        32'h1,      1,0,0,0));
        tbl.push_back(mk(0,0,4'b0101,4'b0001,32'h0,        32'h2,      2,0,0,0));
        tbl.push_back(mk(0,0,4'b0001,4'b0001,32'h0,        32'h3,      2,1,4,0));

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            rst = tbl[i].rst; freeze = tbl[i].frz;
            drive(tbl[i].v, tbl[i].r, tbl[i].d);
            @(posedge clk); #1;
            check($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].out, tbl[i].ev, tbl[i].code, tbl[i].chan);
        end

        // Stall of T-1 cycles then accept: counter must restart cleanly.
        do_reset();
        for (int i = 0; i < int'(T) - 1; i++) begin
            @(negedge clk); drive(4'b1000, 4'b0000, 32'h55000000);
        end
        @(negedge clk); drive(4'b1000, 4'b1000, 32'h55000000);
        for (int i = 0; i < int'(T) - 1; i++) begin
            @(negedge clk); drive(4'b1000, 4'b0000, 32'h55000000);
        end
        @(posedge clk); #1;
        check("stall_below_limit", 32'h01000000, 0, 0, 0, 0);

        // Exact timeout on the T-th stalled cycle, then held.
        do_reset();
        for (int i = 1; i <= int'(T); i++) begin
            @(negedge clk); drive(4'b1000, 4'b0000, 32'h55000000);
            @(posedge clk); #1;
            if (i == int'(T) - 1) check("timeout_pre", 32'h0, 0, 0, 0, 0);
            if (i == int'(T))     check("timeout_hit", 32'h0, 0, 1, 3, 3);
        end
        repeat (5) @(posedge clk);
        #1 check("timeout_hold", 32'h0, 0, 1, 3, 3);

        // Asynchronous reset mid-pending, after a freeze toggle.
        do_reset();
        drive(4'b0001, 4'b0001, 32'h0);
        @(negedge clk); drive(4'b0010, 4'b0000, 32'h7700);
        @(negedge clk); freeze = 1'b1;
        @(negedge clk); freeze = 1'b0;
        @(posedge clk); #1;
        check("pre_async_reset", 32'h1, 1, 0, 0, 0);
        #2 rst = 1'b1;
        #1 check("async_reset", 32'h0, 0, 0, 0, 0);
        @(negedge clk); rst = 1'b0; drive(4'b0000, 4'b0000, 32'h0);
        @(posedge clk); #1;
        check("post_reset_no_drop", 32'h0, 0, 0, 0, 0);
        @(negedge clk); drive(4'b0100, 4'b0100, 32'h0);
        @(posedge clk); #1;
        check("post_reset_fire", 32'h10000, 0, 0, 0, 0);

        // Fire counter wraps without error.
        do_reset();
        drive(4'b0100, 4'b0100, 32'h0);
        repeat (260) @(posedge clk);
        @(negedge clk); drive(4'b0000, 4'b0000, 32'h0);
        check("cnt_wrap", 32'h40000, 0, 0, 0, 0);

        // Random traffic against the reference model.
        fired = '0;
        for (int c = 0; c < int'(NC); c++) cd[c] = '0;
        cv = '0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (i % 250 == 0) begin
                rst = 1'b1; freeze = 1'b0; drive(4'h0, 4'h0, 32'h0);
                cv = '0; fired = '0;
                for (int c = 0; c < int'(NC); c++) bias[c] = int'($urandom_range(0, 8));
                m_reset();
                @(posedge clk); #1;
                check($sformatf("rnd_reset%0d", i), 32'h0, 0, 0, 0, 0);
                @(negedge clk);
                rst = 1'b0;
            end
            for (int c = 0; c < int'(NC); c++) begin
                if (fired[c] || $urandom_range(0, 7) == 0) begin
                    cv[c] = 1'($urandom_range(0, 1));
                    cd[c] = 8'($urandom_range(0, 3));
                end else if ($urandom_range(0, 31) == 0) begin
                    cd[c] = 8'($urandom_range(0, 3));
                end
                cr[c] = (int'($urandom_range(0, 7)) < bias[c]);
            end
            fired  = cv & cr;
            freeze = ($urandom_range(0, 15) == 0);
            drive(cv, cr, {cd[3], cd[2], cd[1], cd[0]});
            if (!freeze) m_step(cv, cr, {cd[3], cd[2], cd[1], cd[0]});
            else         fired = '0;
            @(posedge clk); #1;
            check($sformatf("rnd%0d", i), m_cnt_packed(), 2'(m_out), m_ev, 3'(m_code), 2'(m_chan));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
